// File: rtl/ezusb_tx_arbiter_if.sv
// ezusb_tx_arbiter_if: channel-side and EZ-USB-side stream signals of the TX arbiter
interface ezusb_tx_arbiter_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0]    ch_enable;
  logic [16*NUM_CH-1:0] ch_avail;
  logic [16*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH-1:0]    ch_ready;
  logic [15:0]          DI;
  logic                 DI_valid;
  logic                 DI_ready;
  logic [3:0]           grant;
  logic                 busy;
  modport master (
    input  ch_enable, ch_avail, ch_data, ch_valid, DI_ready,
    output ch_ready, DI, DI_valid, grant, busy
  );
  modport slave (
    output ch_enable, ch_avail, ch_data, ch_valid, DI_ready,
    input  ch_ready, DI, DI_valid, grant, busy
  );
endinterface

// File: rtl/ezusb_tx_arbiter.sv
// ezusb_tx_arbiter: round-robin burst scheduler sharing the EZ-USB DI stream between channels
module ezusb_tx_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 256
) (
  input  logic ifclk,
  input  logic reset,
  ezusb_tx_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, g_q, pick, off, rr_n;
  logic [PW:0] sum;
  logic [12:0] rem_q, len_n;
  logic [15:0] hdr_q, pick_av, sel_data;
  logic [NUM_CH-1:0] elig, rot;
  logic sel_valid, found, acc;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
    assign elig[i] = bus.ch_enable[i] && bus.ch_avail[16*i +: 16] != 16'd0;
  end
  // rotate so bit 0 is rr_ptr; lowest set bit is the next channel in round-robin order
  assign rot = NUM_CH'({elig, elig} >> rr_ptr);
  assign found = |elig;
  always_comb begin
    off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) off = PW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    pick = sum >= (PW+1)'(NUM_CH) ? PW'(sum - (PW+1)'(NUM_CH)) : PW'(sum);
    rr_n = pick == PW'(NUM_CH - 1) ? '0 : pick + PW'(1);
    pick_av = '0;
    sel_data = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (PW'(i) == pick) pick_av = bus.ch_avail[16*i +: 16];
      if (PW'(i) == g_q) begin
        sel_data = bus.ch_data[16*i +: 16];
        sel_valid = bus.ch_valid[i];
      end
    end
    len_n = pick_av > 16'(MAX_BURST) ? 13'(MAX_BURST) : 13'(pick_av);
  end
  assign acc = state == DATA && sel_valid && bus.DI_ready;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (found ? HDR : IDLE) :
              state == HDR  ? (bus.DI_ready ? DATA : HDR) :
              (acc && rem_q == 13'd1) ? IDLE : DATA;
  end
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      g_q <= '0;
      rem_q <= '0;
      hdr_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        g_q <= pick;
        rem_q <= len_n;
        rr_ptr <= rr_n;
        hdr_q <= {4'(pick), 12'(len_n - 13'd1)};
      end else if (acc) begin
        rem_q <= rem_q - 13'd1;
      end
    end
  end
  assign bus.DI = state == HDR ? hdr_q : state == DATA ? sel_data : 16'h0000;
  assign bus.DI_valid = state == HDR || (state == DATA && sel_valid);
  assign bus.ch_ready = acc ? NUM_CH'(1) << g_q : '0;
  assign bus.grant = 4'(g_q);
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_ezusb_tx_arbiter.sv
// tb_ezusb_tx_arbiter: directed checks of burst order, headers, clipping, stalls and reset
module tb_ezusb_tx_arbiter;
  logic ifclk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_err = 0, cyc = 0, bad_rdy = 0, bad_stab = 0;
  logic [15:0] pushed [4];
  logic [15:0] popped [4] = '{default: 16'd0};
  logic [3:0] valid_en;
  logic [15:0] got [$];
  int stamp [$];
  logic stall = 1'b0;
  logic [15:0] stall_di = '0;

  always #5 ifclk = ~ifclk;

  ezusb_tx_arbiter_if #(.NUM_CH(4)) bus ();
  ezusb_tx_arbiter #(.NUM_CH(4), .MAX_BURST(256)) dut (.ifclk(ifclk), .reset(reset), .bus(bus));

  // each channel is a FIFO whose head word encodes {D, channel, pop count}
  for (genvar g = 0; g < 4; g++) begin : src
    assign bus.ch_avail[16*g +: 16] = pushed[g] - popped[g];
    assign bus.ch_valid[g] = valid_en[g] && pushed[g] != popped[g];
    assign bus.ch_data[16*g +: 16] = {4'hD, 4'(g), popped[g][7:0]};
    always @(posedge ifclk) if (bus.ch_ready[g]) popped[g] <= popped[g] + 16'd1;
  end

  always @(posedge ifclk) cyc++;

  always @(negedge ifclk) begin
    if (!reset && bus.DI_valid && bus.DI_ready) begin
      got.push_back(bus.DI);
      stamp.push_back(cyc);
    end
    if (bus.ch_ready != 4'd0 && (!bus.busy || bus.ch_ready != (4'b1 << bus.grant) || !bus.DI_ready || !bus.DI_valid))
      bad_rdy++;
    if (stall && !reset && (!bus.DI_valid || bus.DI !== stall_di)) bad_stab++;
    stall = !reset && bus.DI_valid && !bus.DI_ready;
    stall_di = bus.DI;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_words(input int n, input int limit);
    int t = 0;
    while (got.size() < n && t < limit) begin
      @(posedge ifclk); #1;
      t++;
    end
    chk("word_count_reached", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic clear();
    got.delete();
    stamp.delete();
  endtask

  function automatic logic [15:0] dw(input int c, input int p);
    return {4'hD, 4'(c), 8'(p)};
  endfunction

  initial begin
    logic [15:0] exp2 [12];
    logic [15:0] exp4 [10];
    logic [15:0] exp6 [7];
    pushed = '{default: 16'd0};
    valid_en = 4'hF;
    bus.ch_enable = 4'hF;
    bus.DI_ready = 1'b0;
    repeat (3) @(posedge ifclk);
    #1;
    chk("rst_DI_valid", 32'(bus.DI_valid), 0);
    chk("rst_ch_ready", 32'(bus.ch_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_DI", 32'(bus.DI), 0);
    // single channel burst of 3
    reset = 1'b0;
    bus.DI_ready = 1'b1;
    pushed[1] = 16'd3;
    wait_words(4, 50);
    chk("t1_hdr", 32'(got[0]), 32'h1002);
    chk("t1_d0", 32'(got[1]), 32'(dw(1, 0)));
    chk("t1_d1", 32'(got[2]), 32'(dw(1, 1)));
    chk("t1_d2", 32'(got[3]), 32'(dw(1, 2)));
    repeat (3) @(posedge ifclk);
    #1;
    chk("t1_popped", 32'(popped[1]), 3);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_idle_valid", 32'(bus.DI_valid), 0);
    chk("t1_no_extra", 32'(got.size()), 4);
    // all four channels with 2 words, round-robin from ch0
    reset = 1'b1;
    @(posedge ifclk); #1;
    reset = 1'b0;
    clear();
    for (int i = 0; i < 4; i++) pushed[i] = pushed[i] + 16'd2;
    exp2 = '{16'h0001, dw(0, 0), dw(0, 1), 16'h1001, dw(1, 3), dw(1, 4),
             16'h2001, dw(2, 0), dw(2, 1), 16'h3001, dw(3, 0), dw(3, 1)};
    wait_words(12, 100);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_word%0d", i), 32'(got[i]), 32'(exp2[i]));
    for (int k = 0; k < 3; k++) chk($sformatf("t2_gap%0d", k), 32'(stamp[3*k+3] - stamp[3*k+2]), 2);
    // clipping of a 600-word channel into 256/256/88
    clear();
    pushed[2] = pushed[2] + 16'd600;
    wait_words(603, 2000);
    chk("t3_hdr0", 32'(got[0]), 32'h20FF);
    chk("t3_hdr1", 32'(got[257]), 32'h20FF);
    chk("t3_hdr2", 32'(got[514]), 32'h2057);
    chk("t3_first", 32'(got[1]), 32'(dw(2, 2)));
    chk("t3_b1_last", 32'(got[256]), 32'(dw(2, 257)));
    chk("t3_last", 32'(got[602]), 32'(dw(2, 601)));
    chk("t3_gap1", 32'(stamp[257] - stamp[256]), 2);
    chk("t3_gap2", 32'(stamp[514] - stamp[513]), 2);
    repeat (4) @(posedge ifclk);
    #1;
    chk("t3_count", 32'(got.size()), 603);
    chk("t3_popped", 32'(popped[2]), 602);
    // random DI_ready stalls; rr_ptr now points at ch3
    clear();
    pushed[3] = pushed[3] + 16'd5;
    pushed[0] = pushed[0] + 16'd3;
    exp4 = '{16'h3004, dw(3, 2), dw(3, 3), dw(3, 4), dw(3, 5), dw(3, 6),
             16'h0002, dw(0, 2), dw(0, 3), dw(0, 4)};
    for (int t = 0; t < 400 && got.size() < 10; t++) begin
      bus.DI_ready = 1'($urandom_range(0, 1));
      @(posedge ifclk); #1;
    end
    bus.DI_ready = 1'b1;
    chk("t4_count_reached", 32'(got.size() >= 10), 1);
    for (int i = 0; i < 10; i++) chk($sformatf("t4_word%0d", i), 32'(got[i]), 32'(exp4[i]));
    repeat (4) @(posedge ifclk);
    #1;
    chk("t4_count", 32'(got.size()), 10);
    // valid gap and enable drop mid-burst
    clear();
    pushed[0] = pushed[0] + 16'd4;
    wait_words(3, 50);
    valid_en[0] = 1'b0;
    bus.ch_enable[0] = 1'b0;
    repeat (3) @(posedge ifclk);
    #1;
    chk("t5_gap_count", 32'(got.size()), 3);
    chk("t5_gap_valid", 32'(bus.DI_valid), 0);
    chk("t5_gap_busy", 32'(bus.busy), 1);
    chk("t5_gap_grant", 32'(bus.grant), 0);
    valid_en[0] = 1'b1;
    wait_words(5, 50);
    chk("t5_hdr", 32'(got[0]), 32'h0003);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_d%0d", i), 32'(got[i+1]), 32'(dw(0, 5 + i)));
    repeat (2) @(posedge ifclk);
    #1;
    chk("t5_done_busy", 32'(bus.busy), 0);
    bus.ch_enable[0] = 1'b1;
    // reset after 2 of 5 words; ch0 must be granted first afterwards
    clear();
    pushed[1] = pushed[1] + 16'd5;
    wait_words(3, 50);
    chk("t6_pre_hdr", 32'(got[0]), 32'h1004);
    chk("t6_pre_d1", 32'(got[2]), 32'(dw(1, 6)));
    pushed[0] = pushed[0] + 16'd2;
    reset = 1'b1;
    bus.DI_ready = 1'b0;
    @(posedge ifclk); #1;
    chk("t6_rst_valid", 32'(bus.DI_valid), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_ready", 32'(bus.ch_ready), 0);
    chk("t6_rst_grant", 32'(bus.grant), 0);
    reset = 1'b0;
    bus.DI_ready = 1'b1;
    clear();
    exp6 = '{16'h0001, dw(0, 9), dw(0, 10), 16'h1002, dw(1, 7), dw(1, 8), dw(1, 9)};
    wait_words(7, 60);
    for (int i = 0; i < 7; i++) chk($sformatf("t6_word%0d", i), 32'(got[i]), 32'(exp6[i]));
    repeat (4) @(posedge ifclk);
    #1;
    chk("ch_ready_protocol", 32'(bad_rdy), 0);
    chk("stall_stability", 32'(bad_stab), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
